// File: rtl/alu_issue_if.sv
// Bundles the decode-side, ALU-side and memory-side signals of alu_issue_ctrl.
// slave is the issue controller; master is whatever surrounds it.
interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            id_valid;
    logic            id_ready;
    logic [1:0]      id_class;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic            id_use_imm;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;
    logic [XLEN-1:0] id_imm;
    logic [RD_W-1:0] id_rd;
    logic            flush;

    logic [XLEN-1:0] alu_r1;
    logic [XLEN-1:0] alu_r2;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_branch;
    logic            out_taken;
    logic            out_illegal;

    modport slave (
        input  id_valid, id_class, id_funct3, id_funct7b5, id_use_imm,
               id_rs1_val, id_rs2_val, id_imm, id_rd, flush,
               alu_result, alu_zero, out_ready,
        output id_ready, alu_r1, alu_r2, alu_op,
               out_valid, out_result, out_rd, out_branch, out_taken, out_illegal
    );

    modport master (
        output id_valid, id_class, id_funct3, id_funct7b5, id_use_imm,
               id_rs1_val, id_rs2_val, id_imm, id_rd, flush,
               alu_result, alu_zero, out_ready,
        input  id_ready, alu_r1, alu_r2, alu_op,
               out_valid, out_result, out_rd, out_branch, out_taken, out_illegal
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage front end for the ALU: decodes class/funct into alu_op, holds operands
// in register A, and registers the ALU result and branch decision in register B.
module alu_issue_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    alu_issue_if.slave   bus
);

    typedef enum logic [3:0] {
        ALU_AND     = 4'b0000,
        ALU_OR      = 4'b0001,
        ALU_ADD     = 4'b0010,
        ALU_SUB     = 4'b0110,
        ALU_SLTU    = 4'b0111,
        ALU_ILLEGAL = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        CLS_MEM    = 2'b00,
        CLS_BRANCH = 2'b01,
        CLS_RTYPE  = 2'b10,
        CLS_ITYPE  = 2'b11
    } id_class_e;

    typedef struct packed {
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        alu_op_e         op;
        logic [RD_W-1:0] rd;
        logic            branch;
        logic            taken_on_zero;
        logic            illegal;
    } a_reg_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [RD_W-1:0] rd;
        logic            branch;
        logic            taken;
        logic            illegal;
    } b_reg_t;

    logic    a_valid_q, a_valid_d;
    a_reg_t  a_q, a_d;
    logic    out_valid_q, out_valid_d;
    b_reg_t  b_q, b_d;

    alu_op_e         dec_op;
    logic            dec_branch;
    logic            dec_taken_on_zero;
    logic            dec_illegal;
    logic [RD_W-1:0] dec_rd;

    logic b_free;
    logic a_adv;
    logic id_ready;
    logic a_load;
    logic b_load;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        dec_op            = ALU_ILLEGAL;
        dec_branch        = 1'b0;
        dec_taken_on_zero = 1'b0;
        dec_illegal       = 1'b1;

        unique case (id_class_e'(bus.id_class))
            CLS_MEM: begin
                dec_op      = ALU_ADD;
                dec_illegal = 1'b0;
            end
            CLS_RTYPE, CLS_ITYPE: begin
                dec_illegal = 1'b0;
                case (bus.id_funct3)
                    3'b000: dec_op = (bus.id_class == CLS_RTYPE && bus.id_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b111: dec_op = ALU_AND;
                    3'b110: dec_op = ALU_OR;
                    3'b011: dec_op = ALU_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            CLS_BRANCH: begin
                // Equality tests subtract; unsigned ordering uses SLTU, and zero picks the sense.
                dec_illegal = 1'b0;
                dec_branch  = 1'b1;
                case (bus.id_funct3)
                    3'b000: begin dec_op = ALU_SUB;  dec_taken_on_zero = 1'b1; end
                    3'b001: begin dec_op = ALU_SUB;  dec_taken_on_zero = 1'b0; end
                    3'b110: begin dec_op = ALU_SLTU; dec_taken_on_zero = 1'b0; end
                    3'b111: begin dec_op = ALU_SLTU; dec_taken_on_zero = 1'b1; end
                    default: begin dec_illegal = 1'b1; dec_branch = 1'b0; end
                endcase
            end
        endcase

        if (dec_illegal) begin
            dec_op = ALU_ILLEGAL;
        end
        dec_rd = (dec_illegal || dec_branch) ? '0 : bus.id_rd;
    end

    always_comb begin
        b_free   = !out_valid_q || bus.out_ready;
        a_adv    = a_valid_q && b_free;
        id_ready = !a_valid_q || b_free;
        a_load   = bus.id_valid && id_ready && !bus.flush;
        b_load   = a_adv && !bus.flush;
    end

    always_comb begin
        a_d       = a_q;
        a_valid_d = a_valid_q;

        if (a_load) begin
            a_valid_d       = 1'b1;
            a_d.r1          = bus.id_rs1_val;
            a_d.r2          = bus.id_use_imm ? bus.id_imm : bus.id_rs2_val;
            a_d.op          = dec_op;
            a_d.rd          = dec_rd;
            a_d.branch      = dec_branch;
            a_d.taken_on_zero = dec_taken_on_zero;
            a_d.illegal     = dec_illegal;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end

        if (bus.flush) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        b_d         = b_q;
        out_valid_d = out_valid_q;

        if (b_load) begin
            out_valid_d = 1'b1;
            b_d.result  = a_q.illegal ? '0 : bus.alu_result;
            b_d.rd      = a_q.rd;
            b_d.branch  = a_q.branch;
            b_d.taken   = a_q.branch && (a_q.taken_on_zero ? bus.alu_zero : !bus.alu_zero);
            b_d.illegal = a_q.illegal;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: data registers are reset too, so the ALU and memory stage see zeros, not X.
            a_valid_q   <= 1'b0;
            a_q         <= '0;
            out_valid_q <= 1'b0;
            b_q         <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            a_q         <= a_d;
            out_valid_q <= out_valid_d;
            b_q         <= b_d;
        end
    end

    assign bus.id_ready    = id_ready;
    assign bus.alu_r1      = a_q.r1;
    assign bus.alu_r2      = a_q.r2;
    assign bus.alu_op      = a_q.op;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = b_q.result;
    assign bus.out_rd      = b_q.rd;
    assign bus.out_branch  = b_q.branch;
    assign bus.out_taken   = b_q.taken;
    assign bus.out_illegal = b_q.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: the bench plays the ALU, predicts each accepted
// instruction from its semantics, and a negedge monitor compares what leaves register B.
module tb_alu_issue_ctrl;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef struct {
        logic [1:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic        use_imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [3:0]  op;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        br;
        logic        tk;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

    alu_issue_ctrl #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the ALU the block drives.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_op)
            4'b0000: bus.alu_result = bus.alu_r1 & bus.alu_r2;
            4'b0001: bus.alu_result = bus.alu_r1 | bus.alu_r2;
            4'b0010: bus.alu_result = bus.alu_r1 + bus.alu_r2;
            4'b0110: bus.alu_result = bus.alu_r1 - bus.alu_r2;
            4'b0111: bus.alu_result = (bus.alu_r1 < bus.alu_r2) ? 32'd1 : 32'd0;
            default: bus.alu_result = '0;
        endcase
    end
    assign bus.alu_zero = (bus.alu_result == '0);

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    exp_t a_exp;
    bit   a_occ = 1'b0;
    bit   b_occ = 1'b0;
    bit   mon_en = 1'b0;
    bit   last_accepted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict(input instr_t i);
        exp_t        e;
        logic [31:0] b;
        b     = i.use_imm ? i.imm : i.rs2;
        e.r1  = i.rs1;
        e.r2  = b;
        e.rd  = i.rd;
        e.br  = 1'b0;
        e.tk  = 1'b0;
        e.ill = 1'b0;
        e.op  = 4'b0010;
        e.res = i.rs1 + b;
        case (i.cls)
            2'b00: ;
            2'b10, 2'b11: begin
                case (i.f3)
                    3'b000: if (i.cls == 2'b10 && i.f7) begin e.op = 4'b0110; e.res = i.rs1 - b; end
                    3'b111: begin e.op = 4'b0000; e.res = i.rs1 & b; end
                    3'b110: begin e.op = 4'b0001; e.res = i.rs1 | b; end
                    3'b011: begin e.op = 4'b0111; e.res = (i.rs1 < b) ? 32'd1 : 32'd0; end
                    default: e.ill = 1'b1;
                endcase
            end
            default: begin
                e.br = 1'b1;
                e.rd = '0;
                case (i.f3)
                    3'b000: begin e.op = 4'b0110; e.res = i.rs1 - b; e.tk = (i.rs1 == b); end
                    3'b001: begin e.op = 4'b0110; e.res = i.rs1 - b; e.tk = (i.rs1 != b); end
                    3'b110: begin e.op = 4'b0111; e.res = (i.rs1 < b) ? 32'd1 : 32'd0; e.tk = (i.rs1 < b); end
                    3'b111: begin e.op = 4'b0111; e.res = (i.rs1 < b) ? 32'd1 : 32'd0; e.tk = (i.rs1 >= b); end
                    default: e.ill = 1'b1;
                endcase
            end
        endcase
        if (e.ill) begin
            e.op  = 4'b1111;
            e.res = '0;
            e.rd  = '0;
            e.br  = 1'b0;
            e.tk  = 1'b0;
        end
        return e;
    endfunction

    function automatic instr_t mk(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                                  input logic use_imm, input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [4:0] rd);
        instr_t i;
        i.cls = cls; i.f3 = f3; i.f7 = f7; i.use_imm = use_imm;
        i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.rd = rd;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.cls     = 2'($urandom_range(0, 3));
        i.f3      = 3'($urandom_range(0, 7));
        i.f7      = 1'($urandom_range(0, 1));
        i.use_imm = 1'($urandom_range(0, 1));
        i.rs1     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
        i.rs2     = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom;
        i.imm     = ($urandom_range(0, 1) == 0) ? i.rs1 : $urandom;
        i.rd      = 5'($urandom_range(0, 31));
        return i;
    endfunction

    // Occupancy model of the two stages; updated with the inputs that were present at the edge.
    task automatic model_edge(input bit v, input instr_t ins, input bit fl, input bit ordy);
        bit b_free, adv, load;
        b_free = !b_occ || ordy;
        adv    = a_occ && b_free;
        load   = v && (!a_occ || b_free) && !fl;
        if (fl && a_occ) void'(exp_q.pop_back());
        b_occ = (adv && !fl) ? 1'b1 : (ordy ? 1'b0 : b_occ);
        a_occ = fl ? 1'b0 : (load ? 1'b1 : (adv ? 1'b0 : a_occ));
        if (load) begin
            a_exp = predict(ins);
            exp_q.push_back(a_exp);
        end
        last_accepted = load;
    endtask

    task automatic cycle(input bit v, input instr_t ins, input bit fl, input bit ordy);
        bus.id_valid    = v;
        bus.id_class    = ins.cls;
        bus.id_funct3   = ins.f3;
        bus.id_funct7b5 = ins.f7;
        bus.id_use_imm  = ins.use_imm;
        bus.id_rs1_val  = ins.rs1;
        bus.id_rs2_val  = ins.rs2;
        bus.id_imm      = ins.imm;
        bus.id_rd       = ins.rd;
        bus.flush       = fl;
        bus.out_ready   = ordy;
        @(posedge clk);
        model_edge(v, ins, fl, ordy);
        #1;
    endtask

    task automatic issue(input instr_t ins);
        for (int t = 0; t < 20; t++) begin
            cycle(1'b1, ins, 1'b0, 1'b1);
            if (last_accepted) return;
        end
        check("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input bit ordy);
        instr_t z;
        z = mk(2'b00, 3'b000, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int k = 0; k < n; k++) cycle(1'b0, z, 1'b0, ordy);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("out_valid", 32'(bus.out_valid), 32'(b_occ));
            check("id_ready", 32'(bus.id_ready), 32'(!a_occ || !b_occ || bus.out_ready));
            if (a_occ) begin
                check("alu_r1", bus.alu_r1, a_exp.r1);
                check("alu_r2", bus.alu_r2, a_exp.r2);
                check("alu_op", 32'(bus.alu_op), 32'(a_exp.op));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_result", bus.out_result, e.res);
                    check("out_rd", 32'(bus.out_rd), 32'(e.rd));
                    check("out_branch", 32'(bus.out_branch), 32'(e.br));
                    check("out_taken", 32'(bus.out_taken), 32'(e.tk));
                    check("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_id_ready"}, 32'(bus.id_ready), 32'd1);
        check({tag, "_alu_r1"}, bus.alu_r1, 32'd0);
        check({tag, "_alu_r2"}, bus.alu_r2, 32'd0);
        check({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
        check({tag, "_out_result"}, bus.out_result, 32'd0);
        check({tag, "_out_rd"}, 32'(bus.out_rd), 32'd0);
        check({tag, "_out_flags"}, {29'd0, bus.out_branch, bus.out_taken, bus.out_illegal}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t i1, i2, i3;
        rst = 1'b1;
        idle(0, 1'b0);
        bus.id_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus.id_class = '0; bus.id_funct3 = '0; bus.id_funct7b5 = 1'b0; bus.id_use_imm = 1'b0;
        bus.id_rs1_val = '0; bus.id_rs2_val = '0; bus.id_imm = '0; bus.id_rd = '0;
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // ADD 5+7 -> 12, rd 3; alu_op is ADD while in the EX cycle
        issue(mk(2'b10, 3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3));
        check("ex_alu_op_add", 32'(bus.alu_op), 32'h2);
        idle(1, 1'b1);
        check("add_out_result", bus.out_result, 32'd12);
        check("add_out_rd", 32'(bus.out_rd), 32'd3);

        // SUB 3-5 and ANDI 0x1234 & 0xF0
        issue(mk(2'b10, 3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 5'd4));
        check("ex_alu_op_sub", 32'(bus.alu_op), 32'h6);
        issue(mk(2'b11, 3'b111, 1'b0, 1'b1, 32'h1234, 32'd0, 32'hF0, 5'd6));
        idle(1, 1'b1);
        check("andi_out_result", bus.out_result, 32'h30);

        // Branches
        issue(mk(2'b01, 3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 5'd7));
        issue(mk(2'b01, 3'b001, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 5'd7));
        issue(mk(2'b01, 3'b110, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd7));
        issue(mk(2'b01, 3'b111, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd7));
        idle(1, 1'b1);
        check("bgeu_out_taken", 32'(bus.out_taken), 32'd0);

        // Illegal R-type XOR
        issue(mk(2'b10, 3'b100, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 5'd9));
        check("ex_alu_op_illegal", 32'(bus.alu_op), 32'hF);
        idle(1, 1'b1);
        check("xor_out_illegal", 32'(bus.out_illegal), 32'd1);

        // Back-pressure: fill A and B, stall for 3 cycles, then release
        i1 = mk(2'b10, 3'b000, 1'b0, 1'b0, 32'd10, 32'd20, 32'd0, 5'd1);
        i2 = mk(2'b10, 3'b110, 1'b0, 1'b0, 32'h0F, 32'hF0, 32'd0, 5'd2);
        i3 = mk(2'b11, 3'b011, 1'b0, 1'b1, 32'd4, 32'd0, 32'd9, 5'd3);
        cycle(1'b1, i1, 1'b0, 1'b0);
        cycle(1'b1, i2, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, i3, 1'b0, 1'b0);
        check("stall_id_ready", 32'(bus.id_ready), 32'd0);
        issue(i3);
        idle(3, 1'b1);
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Flush kills the op in A and the same-cycle input
        cycle(1'b1, i1, 1'b0, 1'b1);
        cycle(1'b1, i2, 1'b1, 1'b1);
        idle(3, 1'b1);
        check("flush_no_out", 32'(bus.out_valid), 32'd0);
        check("flush_sb_empty", 32'(exp_q.size()), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 9) < 7));
        end
        idle(4, 1'b1);
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Reset while both registers are full
        cycle(1'b1, i1, 1'b0, 1'b0);
        cycle(1'b1, i2, 1'b0, 1'b0);
        mon_en = 1'b0;
        bus.id_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        a_occ = 1'b0;
        b_occ = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        issue(mk(2'b00, 3'b010, 1'b0, 1'b1, 32'h100, 32'd0, 32'h24, 5'd12));
        idle(2, 1'b1);
        check("post_reset_drained", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage front end that drives the `alu` block: it decodes instruction class/funct fields into the 4-bit `alu_op`, registers the operands, and presents `r1`, `r2` and `alu_op`.
- It then consumes `result` and `zero` to produce a registered writeback value and the branch decision.
- It is a two-register pipeline (ID/EX operand register A, EX/MEM output register B) with valid/ready handshakes on both sides.
- It sits between the decode/register-file stage and the memory stage.

Parameters:
- XLEN, 32, datapath width; must equal the ALU word width.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  block accepts the instruction this cycle.
- id_class  in  2  00 load/store address, 01 branch, 10 R-type, 11 I-type arithmetic.
- id_funct3  in  3  instruction funct3.
- id_funct7b5  in  1  instruction bit 30.
- id_use_imm  in  1  1: second operand is `id_imm`; 0: second operand is `id_rs2_val`.
- id_rs1_val  in  XLEN  first operand.
- id_rs2_val  in  XLEN  second register operand.
- id_imm  in  XLEN  sign-extended immediate.
- id_rd  in  RD_W  destination register.
- flush  in  1  synchronous kill of register A and of any same-cycle input handshake.
- alu_r1  out  XLEN  to ALU `r1` (register A operand 1).
- alu_r2  out  XLEN  to ALU `r2` (register A operand 2).
- alu_op  out  4  to ALU opcode.
- alu_result  in  XLEN  from ALU.
- alu_zero  in  1  from ALU.
- out_valid  out  1  register B holds a result.
- out_ready  in  1  memory stage accepts register B.
- out_result  out  XLEN  registered ALU result; forced 0 on illegal.
- out_rd  out  RD_W  destination; 0 for branches and illegal ops.
- out_branch  out  1  register B holds a branch.
- out_taken  out  1  branch resolved taken.
- out_illegal  out  1  undecodable class/funct combination.

Behaviour:
- Reset (async, `rst`=1):
  - `a_valid`=0 and `out_valid`=0.
  - All data registers cleared to 0, so `alu_r1`=`alu_r2`=0 and `alu_op`=4'b0000.
  - `out_result`=0, `out_rd`=0, `out_branch`=0, `out_taken`=0, `out_illegal`=0.
  - Reset mid-operation discards all in-flight instructions.
- Handshake signals:
  - `b_free` = !`out_valid` | `out_ready`.
  - `a_adv` = `a_valid` & `b_free`.
  - `id_ready` = !`a_valid` | `b_free` (combinational, no bubble required).
- Register A load:
  - Loads on `id_valid` & `id_ready` & !`flush`.
  - Captures r1 = `id_rs1_val`; r2 = `id_use_imm` ? `id_imm` : `id_rs2_val`.
  - Captures the decoded op, class/branch condition, and `id_rd`.
- Register A clear: if not loading and `a_adv`, `a_valid`←0. `flush` forces `a_valid`←0 regardless of the load and advance terms. Register B is unaffected by `flush`.
- Register A hold: data fields hold when not loading, so the ALU inputs stay stable while A is stalled.
- Register B:
  - On `a_adv`, captures `alu_result` (or 0 if illegal), `rd`, and the branch/taken/illegal flags; `out_valid`←1.
  - Else if `out_ready`, `out_valid`←0 and data holds.
- Latency and throughput: an instruction accepted at edge k is visible on `out_*` after edge k+1. Throughput is one per cycle when `out_ready`=1.
- Decode (ALU codes AND 0000, OR 0001, ADD 0010, SUB 0110, SLTU 0111):
  - class 00: ADD.
  - class 10, by funct3:
    - 000: SUB if `id_funct7b5`, else ADD.
    - 111: AND.
    - 110: OR.
    - 011: SLTU.
    - all others: illegal.
  - class 11, by funct3:
    - 000: ADD.
    - 111: AND.
    - 110: OR.
    - 011: SLTU.
    - all others: illegal. `id_funct7b5` is ignored.
  - class 01 (branch):
    - 000 BEQ: SUB, taken = `zero`.
    - 001 BNE: SUB, taken = !`zero`.
    - 110 BLTU: SLTU, taken = !`zero`.
    - 111 BGEU: SLTU, taken = `zero`.
    - all others: illegal (signed compares are unsupported by the ALU).
  - Illegal: `alu_op`=4'b1111 (ALU default, result 0), `out_illegal`=1, `out_rd`=0, `out_taken`=0.
- `out_taken` is only meaningful when `out_branch`=1, and is 0 otherwise.
- Simultaneous events:
  - Load and advance in the same cycle: A is replaced, B is filled, and no op is lost.
  - `flush` together with stall: A is emptied and B is kept.

Test Plan:
- Reset, then an R-type ADD with rs1=5, rs2=7, rd=3, `out_ready`=1 → after 2 edges `out_valid`=1, `out_result`=12, `out_rd`=3; during the EX cycle `alu_op`=0010.
- R-type funct3 000, `id_funct7b5`=1, rs1=3, rs2=5 → `out_result`=0xFFFFFFFE, `alu_op`=0110; then ANDI with imm=0xF0 on 0x1234 → 0x30.
- BEQ 9,9 → `out_taken`=1, `out_rd`=0; BNE 9,9 → `out_taken`=0; BLTU 1,2 → `out_taken`=1; BGEU 1,2 → `out_taken`=0.
- R-type funct3 100 (XOR) → `out_illegal`=1, `out_result`=0, `out_rd`=0, `alu_op`=1111.
- Back-to-back ops with `out_ready` held 0 for 3 cycles:
  - `id_ready` drops after A and B are full.
  - The ALU inputs hold stable throughout.
  - After release, results emerge in order with none dropped or duplicated.
- Op in A, `flush`=1 with `id_valid`=1 → neither op reaches B; assert `rst` mid-stream → all valids 0 immediately, outputs 0.
